// File: rtl/seq_shift_mul_unit.sv
// seq_shift_mul_unit
// Multi-cycle execute unit placed after reg_file. It runs one shift step or
// one shift-add multiply step per cycle. On completion it drives a single
// writeback pulse (reg_write/write_data) back into reg_file.
//
// Ports:
//   clk         system clock, rising-edge
//   rst         synchronous active-high reset
//   start       request, sampled only while idle
//   op          000 SLL, 001 SRL, 010 SRA, 011 MUL, 1xx illegal
//   reg_val1    operand A (value to shift / multiplicand)
//   reg_val2    operand B (shift amount in low SHAMT_W bits / multiplier)
//   dest_sel    writeback target: 01 rs, 10 rt, 00 none, 11 invalid
//   busy        high while running and during the completion cycle
//   done        one-cycle completion pulse
//   err         high with done for an illegal op or dest_sel=11
//   result      last completed result, held until the next completion
//   reg_write   latched dest_sel during completion (00 if 11), else 00
//   write_data  result during completion, else 0
module seq_shift_mul_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] reg_val1,
  input  logic [DATA_W-1:0] reg_val2,
  input  logic [1:0]        dest_sel,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] result,
  output logic [1:0]        reg_write,
  output logic [DATA_W-1:0] write_data
);

  // Wide enough to hold DATA_W itself (MUL step count).
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    OP_SLL = 3'b000,
    OP_SRL = 3'b001,
    OP_SRA = 3'b010,
    OP_MUL = 3'b011
  } op_t;

  state_t              state;
  state_t              state_nxt;

  logic [2:0]          op_q;
  logic [1:0]          dest_q;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [DATA_W-1:0]   acc;
  logic [CNT_W-1:0]    count;
  logic [DATA_W-1:0]   result_q;
  logic                err_q;

  logic [CNT_W-1:0]    cnt_load;
  logic [DATA_W-1:0]   acc_load;
  logic [DATA_W-1:0]   acc_step;
  logic                finish_err;
  logic                accept;
  logic                count_zero;

  assign accept     = (state == S_IDLE) && start;
  assign count_zero = (count == '0);
  assign finish_err = op_q[2] | (dest_q == 2'b11);

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (count_zero) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Load values chosen from the incoming op at acceptance
  // ---------------------------------------------------------------------
  always_comb begin
    cnt_load = '0;
    acc_load = '0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: begin
        cnt_load = CNT_W'(reg_val2[SHAMT_W-1:0]);
        acc_load = reg_val1;
      end
      OP_MUL: begin
        cnt_load = CNT_W'(DATA_W);
        acc_load = '0;
      end
      default: begin
        // Illegal op: finishes immediately with a zero result.
        cnt_load = '0;
        acc_load = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // One iteration of the latched operation
  // ---------------------------------------------------------------------
  always_comb begin
    acc_step = acc;
    case (op_q)
      OP_SLL: acc_step = {acc[DATA_W-2:0], 1'b0};
      OP_SRL: acc_step = {1'b0, acc[DATA_W-1:1]};
      OP_SRA: acc_step = {acc[DATA_W-1], acc[DATA_W-1:1]};
      OP_MUL: acc_step = b_q[0] ? (acc + a_q) : acc;
      default: acc_step = acc;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q     <= '0;
      dest_q   <= '0;
      a_q      <= '0;
      b_q      <= '0;
      acc      <= '0;
      count    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          err_q <= 1'b0;
          if (accept) begin
            op_q   <= op;
            dest_q <= dest_sel;
            a_q    <= reg_val1;
            b_q    <= reg_val2;
            count  <= cnt_load;
            acc    <= acc_load;
          end
        end
        S_RUN: begin
          if (count_zero) begin
            result_q <= acc;
            // err is registered on the way into DONE so it is valid only
            // for that single cycle, then cleared on the DONE edge.
            err_q    <= finish_err;
          end else begin
            acc   <= acc_step;
            count <= count - CNT_W'(1);
            if (op_q == OP_MUL) begin
              a_q <= {a_q[DATA_W-2:0], 1'b0};
              b_q <= {1'b0, b_q[DATA_W-1:1]};
            end
          end
        end
        S_DONE: begin
          err_q <= 1'b0;
        end
        default: begin
          err_q <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs: decodes of registered state only
  // ---------------------------------------------------------------------
  always_comb begin
    busy       = (state != S_IDLE);
    done       = (state == S_DONE);
    err        = err_q;
    result     = result_q;
    reg_write  = 2'b00;
    write_data = '0;
    if (state == S_DONE) begin
      write_data = result_q;
      if (dest_q != 2'b11) begin
        reg_write = dest_q;
      end
    end
  end

endmodule

// File: tb/tb_seq_shift_mul_unit.sv
module tb_seq_shift_mul_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] reg_val1;
  logic [31:0] reg_val2;
  logic [1:0]  dest_sel;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] result;
  logic [1:0]  reg_write;
  logic [31:0] write_data;

  seq_shift_mul_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .op         (op),
    .reg_val1   (reg_val1),
    .reg_val2   (reg_val2),
    .dest_sel   (dest_sel),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .result     (result),
    .reg_write  (reg_write),
    .write_data (write_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        err;
    logic [1:0]  rw;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_res = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
    end
  endtask

  // Reference model: plain arithmetic on the operation definitions.
  function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [1:0] d,
                                 input int unsigned e0);
    exp_t        e;
    int unsigned sh;
    int unsigned k;
    sh = b % 32;
    k  = 0;
    e.res = '0;
    case (o)
      3'd0: begin e.res = a << sh; k = sh; end
      3'd1: begin e.res = a >> sh; k = sh; end
      3'd2: begin e.res = $unsigned($signed(a) >>> sh); k = sh; end
      3'd3: begin e.res = a * b; k = 32; end
      default: begin e.res = '0; k = 0; end
    endcase
    e.err = (o > 3'd3) || (d == 2'b11);
    e.rw  = (d == 2'b11) ? 2'b00 : d;
    e.cyc = e0 + k + 1;
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding request.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=done required=no_done result=%h cyc=%0d", result, cyc);
        end else begin
          e = sb.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("result", result, e.res);
          chk("write_data", write_data, e.res);
          chk("err", {31'd0, err}, {31'd0, e.err});
          chk("reg_write", {30'd0, reg_write}, {30'd0, e.rw});
          chk("busy_in_done", {31'd0, busy}, 32'd1);
          last_res = e.res;
        end
      end
    end
  end

  // Called just after a rising edge; start is sampled on the next edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [1:0] d);
    start    = 1'b1;
    op       = o;
    reg_val1 = a;
    reg_val2 = b;
    dest_sel = d;
    sb.push_back(model(o, a, b, d, cyc + 1));
    @(posedge clk); #1;
    start    = 1'b0;
    // Operands are latched, so scrambling them now must not matter.
    op       = 3'($urandom);
    reg_val1 = $urandom;
    reg_val2 = $urandom;
    dest_sel = 2'($urandom);
  endtask

  task automatic wait_done();
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout actual=pending%0d required=0", sb.size());
      sb.delete();
    end else begin
      // First idle cycle after completion.
      chk("idle_done", {31'd0, done}, 32'd0);
      chk("idle_reg_write", {30'd0, reg_write}, 32'd0);
      chk("idle_write_data", write_data, 32'd0);
      chk("held_result", result, last_res);
    end
  endtask

  initial begin
    logic [2:0] ro;
    start = 0; op = 0; reg_val1 = 0; reg_val2 = 0; dest_sel = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_reg_write", {30'd0, reg_write}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    issue(3'd0, 32'h3, 32'd4, 2'b01);
    chk("busy_run", {31'd0, busy}, 32'd1);
    wait_done();
    issue(3'd2, 32'h8000_0000, 32'd31, 2'b01); wait_done();
    issue(3'd1, 32'h8000_0000, 32'd31, 2'b10); wait_done();
    issue(3'd3, 32'd16, 32'd22, 2'b10);        wait_done();
    issue(3'd3, 32'hFFFF_FFFF, 32'd2, 2'b01);  wait_done();

    // Shift by 0 with start held through RUN and DONE: must be ignored.
    issue(3'd0, 32'd9, 32'd0, 2'b01);
    start = 1'b1; op = 3'd3; reg_val1 = 32'd5; reg_val2 = 32'd7; dest_sel = 2'b10;
    @(posedge clk); #1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();
    repeat (3) @(posedge clk);
    #1;

    issue(3'b101, 32'h1234, 32'd3, 2'b01); wait_done();
    issue(3'd0, 32'h1, 32'd3, 2'b11);      wait_done();
    issue(3'd1, 32'hF0, 32'd4, 2'b00);     wait_done();

    // Reset in the middle of a multiply: no completion may appear.
    issue(3'd3, 32'd7, 32'd9, 2'b01);
    repeat (9) @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_done", {31'd0, done}, 32'd0);
    chk("midrst_result", result, 32'd0);
    chk("midrst_reg_write", {30'd0, reg_write}, 32'd0);
    chk("midrst_write_data", write_data, 32'd0);
    rst = 1'b0;
    last_res = '0;
    repeat (40) @(posedge clk);
    #1;
    issue(3'd3, 32'd7, 32'd9, 2'b01); wait_done();

    // Randomized, including back-to-back starts.
    for (int i = 0; i < 40; i++) begin
      ro = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
      issue(ro, $urandom, $urandom, 2'($urandom));
      wait_done();
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
    end

    repeat (5) @(posedge clk);
    #1;
    chk("final_queue_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute safety net.
  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/seq_shift_mul_unit.md
Name: seq_shift_mul_unit

Overview:
Multi-cycle execute unit for the KGP mini-RISC datapath. It sits directly downstream of reg_file and consumes its reg_val1/reg_val2 read outputs. It performs shifts (one bit per cycle) and a shift-add multiply. It then drives reg_write/write_data back into reg_file for exactly one cycle on completion.

Parameters:
DATA_W, 32, operand/result width (matches reg_file data width)
SHAMT_W, 5, shift-amount field width taken from reg_val2[SHAMT_W-1:0]

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
op  input  3  000 SLL, 001 SRL, 010 SRA, 011 MUL (low DATA_W bits), 100-111 illegal
reg_val1  input  DATA_W  operand A (value to shift / multiplicand), from reg_file
reg_val2  input  DATA_W  operand B (shift amount in low SHAMT_W bits / multiplier), from reg_file
dest_sel  input  2  writeback target, same encoding as reg_file reg_write: 01 rs, 10 rt, 00 none
busy  output  1  high in RUN and DONE
done  output  1  one-cycle completion pulse
err  output  1  high with done when op illegal or dest_sel=11
result  output  DATA_W  last completed result, held until next completion
reg_write  output  2  to reg_file; equals latched dest_sel during DONE, else 00
write_data  output  DATA_W  to reg_file; equals result during DONE, else 0

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous, active-high.
- Reset values: state IDLE; busy, done, err = 0; result = 0; reg_write = 00; write_data = 0; internal acc/A/B/count = 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start=1, latch op, dest_sel, A=reg_val1 and B=reg_val2, then go to RUN.
  - Count loads:
    - shifts: reg_val2[SHAMT_W-1:0]
    - MUL: DATA_W
    - illegal op: 0
  - acc loads:
    - shifts: reg_val1
    - MUL: 0
    - illegal: 0
- RUN, each edge:
  - If count==0, go to DONE. result<=acc. err<=(illegal op) | (dest_sel==11).
  - Otherwise perform one step and decrement count:
    - SLL: acc<=acc<<1
    - SRL: acc<=acc>>1 (zero fill)
    - SRA: acc<=acc>>1 (sign fill from acc MSB)
    - MUL: if B[0], acc<=acc+A (mod 2^DATA_W); then A<<=1, B>>=1
- DONE:
  - Lasts exactly one cycle. done=1. write_data=result.
  - reg_write=latched dest_sel; forced to 00 if dest_sel==11.
  - err holds its computed value for this cycle only.
  - Next edge returns to IDLE.
- Latency: start sampled at edge E0 → done high in the cycle after edge E(k+1), where k = shift amount (0..31) or DATA_W for MUL. Illegal op and shift-by-0 give k=0. busy is high from after E0 through the DONE cycle.
- Outputs: done, reg_write and write_data are registered state decodes (no combinational path from inputs).
- start while busy=1, including during the DONE cycle, is ignored and not queued. Operands are latched at start, so later changes on reg_val1/reg_val2 have no effect.
- Back-to-back: start can be accepted on the first IDLE edge after DONE.
- rst mid-operation (RUN or DONE): next state IDLE, all outputs at reset values, no writeback pulse.
- dest_sel=00: normal completion with done=1 and reg_write=00.
- Overflow: MUL keeps the low DATA_W bits only; no flag.

Test Plan:
- SLL, reg_val1=0x00000003, reg_val2=4, dest_sel=01 → done after E5, result=write_data=0x00000030, reg_write=01 for 1 cycle, err=0.
- SRA, reg_val1=0x80000000, reg_val2=31 → result 0xFFFFFFFF after E32. SRL with the same inputs → 0x00000001.
- MUL, reg_val1=16, reg_val2=22, dest_sel=10 → done after E33, write_data=352, reg_write=10.
- MUL 0xFFFFFFFF×2 → result 0xFFFFFFFE (truncation).
- Shift by 0 (reg_val1=9) → done after E1, result 9. Second start pulsed during RUN and during DONE → ignored; exactly one done pulse.
- op=101 → done after E1, err=1, result 0. dest_sel=11 with SLL → err=1, reg_write=00.
- rst=1 at cycle 10 of a MUL → outputs 0 next cycle, no done/reg_write pulse. A new start then completes normally.
